// File: rtl/sound_i2s_out.sv
// Audio output stage: 96 kHz mono samples decimated 2:1 by pair averaging,
// then sent as 16-in-32 I2S with MCLK/SCLK/LRCK taken straight from a phase counter.
module sound_i2s_out (
    input  logic        CLK_AUDIO,
    input  logic        RESET_N,
    input  logic [15:0] SAMPLE_IN,
    input  logic        SAMPLE_EN,
    input  logic        MUTE,
    output logic        I2S_MCLK,
    output logic        I2S_SCLK,
    output logic        I2S_LRCK,
    output logic        I2S_SDATA,
    output logic        UNDERRUN
);

    logic [8:0]        cnt;
    logic              phase;
    logic              valid;
    logic [15:0]       a;
    logic [15:0]       hold;
    logic [15:0]       frame;
    logic              sdata;
    logic              underrun;

    logic signed [16:0] sum;
    logic [15:0]       dec;
    logic              pair_done;
    logic              frame_tick;
    logic              bit_tick;
    logic [4:0]        nxt_pos;
    logic [3:0]        bit_idx;
    logic              nxt_bit;

    always_comb begin
        sum        = $signed({a[15], a}) + $signed({SAMPLE_IN[15], SAMPLE_IN});
        dec        = 16'(sum >>> 1);
        pair_done  = SAMPLE_EN & phase;
        frame_tick = (cnt == 9'd511);
        bit_tick   = (cnt[2:0] == 3'd7);
        // Only evaluated when cnt[2:0]==7, so the carry lands in bit 3.
        nxt_pos    = cnt[7:3] + 5'd1;
        bit_idx    = 4'(5'd16 - nxt_pos);
        nxt_bit    = 1'b0;
        if (nxt_pos != 5'd0 && nxt_pos <= 5'd16)
            nxt_bit = frame[bit_idx];
    end

    always_ff @(posedge CLK_AUDIO) begin
        if (!RESET_N) begin
            cnt      <= '0;
            phase    <= 1'b0;
            valid    <= 1'b0;
            a        <= '0;
            hold     <= '0;
            frame    <= '0;
            sdata    <= 1'b0;
            underrun <= 1'b0;
        end else begin
            cnt      <= cnt + 9'd1;
            underrun <= 1'b0;

            if (SAMPLE_EN) begin
                phase <= ~phase;
                if (!phase)
                    a <= SAMPLE_IN;
                else
                    hold <= dec;
            end

            // Frame load: mute beats a same-cycle pair, which beats a held sample.
            if (frame_tick) begin
                if (MUTE) begin
                    frame <= '0;
                    valid <= 1'b0;
                end else if (pair_done) begin
                    frame <= dec;
                    valid <= 1'b0;
                end else if (valid) begin
                    frame <= hold;
                    valid <= 1'b0;
                end else begin
                    underrun <= 1'b1;
                end
            end else if (pair_done) begin
                valid <= 1'b1;
            end

            if (bit_tick)
                sdata <= nxt_bit;
        end
    end

    assign I2S_MCLK  = cnt[0];
    assign I2S_SCLK  = cnt[2];
    assign I2S_LRCK  = cnt[8];
    assign I2S_SDATA = sdata;
    assign UNDERRUN  = underrun;

endmodule

// File: tb/tb_sound_i2s_out.sv
// Bench for sound_i2s_out: decodes the I2S stream slot by slot and
// compares against a sample-level model of decimation and frame loading.
module tb_sound_i2s_out;

    logic        CLK_AUDIO = 1'b0;
    logic        RESET_N   = 1'b0;
    logic [15:0] SAMPLE_IN = '0;
    logic        SAMPLE_EN = 1'b0;
    logic        MUTE      = 1'b0;
    logic        I2S_MCLK;
    logic        I2S_SCLK;
    logic        I2S_LRCK;
    logic        I2S_SDATA;
    logic        UNDERRUN;

    sound_i2s_out dut (
        .CLK_AUDIO (CLK_AUDIO),
        .RESET_N   (RESET_N),
        .SAMPLE_IN (SAMPLE_IN),
        .SAMPLE_EN (SAMPLE_EN),
        .MUTE      (MUTE),
        .I2S_MCLK  (I2S_MCLK),
        .I2S_SCLK  (I2S_SCLK),
        .I2S_LRCK  (I2S_LRCK),
        .I2S_SDATA (I2S_SDATA),
        .UNDERRUN  (UNDERRUN)
    );

    always #5 CLK_AUDIO = ~CLK_AUDIO;

    int cyc = 0;
    always @(posedge CLK_AUDIO) cyc <= RESET_N ? cyc + 1 : 0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_under  = 0;
    logic        m_half;
    int          m_a;
    logic        m_pend;
    logic [15:0] m_pend_v;
    logic [15:0] m_frame;
    logic [31:0] slot;
    int          nbits;
    logic [15:0] word_l;
    logic [15:0] word_r;
    logic        mute_v;
    logic [15:0] src_q[$];

    task automatic model_reset();
        m_half   = 1'b0;
        m_a      = 0;
        m_pend   = 1'b0;
        m_pend_v = '0;
        m_frame  = '0;
        slot     = '0;
        nbits    = 0;
        mute_v   = 1'b0;
        n_under  = 0;
        word_l   = 16'hDEAD;
        word_r   = 16'hDEAD;
        src_q.delete();
    endtask

    task automatic do_reset(input int n);
        RESET_N   = 1'b0;
        SAMPLE_EN = 1'b0;
        MUTE      = 1'b0;
        repeat (n) begin
            @(negedge CLK_AUDIO);
            n_checks++;
            if ({I2S_MCLK, I2S_SCLK, I2S_LRCK, I2S_SDATA, UNDERRUN} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_outputs got=%b exp=00000",
                         {I2S_MCLK, I2S_SCLK, I2S_LRCK, I2S_SDATA, UNDERRUN});
            end
        end
        RESET_N = 1'b1;
        model_reset();
    endtask

    // One clock: drive inputs, advance the model, then check at the falling edge.
    task automatic step(input logic en, input logic [15:0] v);
        int          c;
        int          nv;
        logic        hv;
        logic        eu;
        logic [8:0]  cc;
        c  = cyc % 512;
        hv = 1'b0;
        nv = 0;
        eu = 1'b0;
        SAMPLE_EN = en;
        SAMPLE_IN = v;
        MUTE      = mute_v;
        if (en) begin
            if (m_half) begin
                nv     = (m_a + int'($signed(v))) >>> 1;
                hv     = 1'b1;
                m_half = 1'b0;
            end else begin
                m_a    = int'($signed(v));
                m_half = 1'b1;
            end
        end
        if (c == 511) begin
            if (mute_v) begin
                m_frame = '0;
                m_pend  = 1'b0;
            end else if (hv) begin
                m_frame = nv[15:0];
                m_pend  = 1'b0;
            end else if (m_pend) begin
                m_frame = m_pend_v;
                m_pend  = 1'b0;
            end else begin
                eu = 1'b1;
            end
        end else if (hv) begin
            m_pend   = 1'b1;
            m_pend_v = nv[15:0];
        end
        @(negedge CLK_AUDIO);
        SAMPLE_EN = 1'b0;
        cc = 9'(cyc % 512);
        n_checks++;
        if (UNDERRUN !== eu) begin
            n_fail++;
            $display("FAIL underrun cyc=%0d got=%b exp=%b", cyc, UNDERRUN, eu);
        end
        if (UNDERRUN === 1'b1) n_under++;
        n_checks++;
        if ({I2S_LRCK, I2S_SCLK, I2S_MCLK} !== {cc[8], cc[2], cc[0]}) begin
            n_fail++;
            $display("FAIL clocks cyc=%0d got=%b exp=%b", cyc,
                     {I2S_LRCK, I2S_SCLK, I2S_MCLK}, {cc[8], cc[2], cc[0]});
        end
        if (cc[2:0] == 3'd4) begin
            slot = {slot[30:0], I2S_SDATA};
            nbits++;
            if (cc[7:0] == 8'd252 && nbits >= 32) begin
                n_checks++;
                if (slot !== {1'b0, m_frame, 15'd0}) begin
                    n_fail++;
                    $display("FAIL slot cyc=%0d got=%h exp=%h", cyc, slot,
                             {1'b0, m_frame, 15'd0});
                end
                if (cc[8]) word_r = slot[30:15];
                else       word_l = slot[30:15];
            end
        end
    endtask

    task automatic run_until(input int target, input int off);
        logic        e;
        logic [15:0] v;
        while (cyc < target) begin
            e = (cyc % 256 == off) && (src_q.size() > 0);
            v = e ? src_q.pop_front() : 16'h0;
            step(e, v);
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        run_until(1100, 0);
        n_checks++;
        if (n_under !== 2) begin
            n_fail++;
            $display("FAIL reset_underrun_count got=%0d exp=2", n_under);
        end
    endtask

    task automatic test_decimation();
        do_reset(3);
        src_q.push_back(16'h1000);
        src_q.push_back(16'h2000);
        run_until(1030, 10);
        n_checks++;
        if (word_l !== 16'h1800 || word_r !== 16'h1800) begin
            n_fail++;
            $display("FAIL decimation got=%h/%h exp=1800", word_l, word_r);
        end
    endtask

    task automatic test_rounding();
        do_reset(3);
        src_q = '{16'hFFFF, 16'h0000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000};
        run_until(800, 10);
        n_checks++;
        if (word_l !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL round_neg got=%h exp=ffff", word_l);
        end
        run_until(1300, 10);
        n_checks++;
        if (word_l !== 16'h7FFF) begin
            n_fail++;
            $display("FAIL round_max got=%h exp=7fff", word_l);
        end
        run_until(1800, 10);
        n_checks++;
        if (word_l !== 16'h8000) begin
            n_fail++;
            $display("FAIL round_min got=%h exp=8000", word_l);
        end
    endtask

    task automatic test_underrun();
        do_reset(3);
        src_q = '{16'h1234, 16'h4321};
        run_until(1800, 10);
        n_checks++;
        if (word_l !== 16'h2AAA) begin
            n_fail++;
            $display("FAIL underrun_repeat got=%h exp=2aaa", word_l);
        end
        n_checks++;
        if (n_under !== 2) begin
            n_fail++;
            $display("FAIL underrun_count got=%0d exp=2", n_under);
        end
    endtask

    task automatic test_bypass();
        do_reset(3);
        src_q = '{16'h0AAA, 16'h0AAA};
        run_until(1000, 255);
        n_checks++;
        if (word_l !== 16'h0AAA) begin
            n_fail++;
            $display("FAIL bypass_word got=%h exp=0aaa", word_l);
        end
        n_checks++;
        if (n_under !== 0) begin
            n_fail++;
            $display("FAIL bypass_underrun got=%0d exp=0", n_under);
        end
    endtask

    task automatic test_mute_reset();
        logic [15:0] r0;
        logic [15:0] r1;
        int          e1;
        do_reset(3);
        for (int i = 0; i < 8; i++) src_q.push_back(16'($urandom));
        r0 = src_q[0];
        r1 = src_q[1];
        e1 = (int'($signed(r0)) + int'($signed(r1))) >>> 1;
        run_until(600, 100);
        mute_v = 1'b1;
        run_until(1030, 100);
        mute_v = 1'b0;
        n_checks++;
        if (word_r !== e1[15:0]) begin
            n_fail++;
            $display("FAIL mute_current got=%h exp=%h", word_r, e1[15:0]);
        end
        run_until(1300, 100);
        n_checks++;
        if (word_l !== 16'h0000) begin
            n_fail++;
            $display("FAIL mute_next got=%h exp=0000", word_l);
        end
        do_reset(1);
        repeat (5) step(1'b0, 16'h0);
        n_checks++;
        if ({I2S_LRCK, I2S_SCLK, I2S_MCLK} !== 3'b011) begin
            n_fail++;
            $display("FAIL restart_cnt got=%b exp=011",
                     {I2S_LRCK, I2S_SCLK, I2S_MCLK});
        end
    endtask

    task automatic test_random();
        int off;
        for (int k = 0; k < 3; k++) begin
            do_reset(2);
            off = int'($urandom_range(0, 255));
            for (int i = 0; i < 10; i++) src_q.push_back(16'($urandom));
            run_until(5 * 512 + 10, off);
        end
    endtask

    initial begin
        test_reset();
        test_decimation();
        test_rounding();
        test_underrun();
        test_bypass();
        test_mute_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_i2s_out.md
# sound_i2s_out

Final audio output stage. Takes the 96 kHz signed 16-bit mixed sound word and its sample strobe from the sound generator, decimates it 2:1 to 48 kHz with a pair-averaging filter, and serializes it as a 16-bit-in-32-bit-slot I2S stream to the Pocket audio DAC. The mono sample is duplicated on left and right. The block also generates MCLK, SCLK and LRCK.

## Interface
Parameters: none. Clock ratios are fixed at 24.576 MHz CLK_AUDIO, 256 clocks per input sample and 512 clocks per output frame.

Ports:
- CLK_AUDIO  in  1  audio clock, 24.576 MHz; all logic on the rising edge.
- RESET_N  in  1  reset, synchronous, active-low.
- SAMPLE_IN  in  16  mixed sound, two's complement.
- SAMPLE_EN  in  1  one-cycle strobe, one per 256 clocks (96 kHz); SAMPLE_IN valid in that cycle.
- MUTE  in  1  when high at a frame boundary, the frame carries 0.
- I2S_MCLK  out  1  master clock, CLK_AUDIO/2 = 12.288 MHz.
- I2S_SCLK  out  1  bit clock, CLK_AUDIO/8 = 3.072 MHz.
- I2S_LRCK  out  1  word select, 48 kHz; 0 = left, 1 = right.
- I2S_SDATA  out  1  serial data, MSB first.
- UNDERRUN  out  1  one-cycle pulse when a frame starts with no new decimated sample.

## Operation
- **Phase counter:** cnt[8:0] is free-running and wraps 511→0.
  - I2S_MCLK = cnt[0], I2S_SCLK = cnt[2], I2S_LRCK = cnt[8]. These are direct flop bits with no combinational decode.
  - Slot bit position: pos = cnt[7:3], range 0..31.
- **Decimator:** a one-bit phase flag toggles on each SAMPLE_EN.
  - phase=0: store a ← SAMPLE_IN; phase ← 1.
  - phase=1: dec ← (sext17(a) + sext17(SAMPLE_IN)) >>> 1, an arithmetic shift that rounds toward −inf and always fits in 16 bits. Then hold ← dec, valid ← 1, phase ← 0.
- **Frame load** happens in the cycle where cnt==511, so the new frame starts at cnt=0. The highest-priority matching case applies:
  1. MUTE=1: frame ← 0; valid ← 0.
  2. A decimated result completes in this same cycle: frame ← dec (bypass hold); valid stays 0.
  3. valid=1: frame ← hold; valid ← 0.
  4. Otherwise frame is unchanged and UNDERRUN pulses high in the next cycle.
- **Overrun:** if a second decimated sample completes before the frame load, hold is overwritten. The latest sample wins and no flag is raised.
- **Serializer:** I2S_SDATA is a register updated only in cycles where cnt[2:0]==7, so it changes with the SCLK falling edge.
  - Let p = next position ((cnt+1)[7:3]).
  - I2S_SDATA ← frame[16−p] for p in 1..16; otherwise 0.
  - The MSB is therefore one SCLK after the LRCK edge (I2S standard). Bits 17..31 and bit 0 of each slot are 0.
  - The right slot repeats the same frame word. The frame register may only change at cnt==511.

## Timing
- **Reset** (RESET_N low at a clock edge): in the next cycle cnt=0, phase=0, valid=0, a=hold=frame=0. All outputs are 0: I2S_MCLK, I2S_SCLK, I2S_LRCK, I2S_SDATA and UNDERRUN. Reset mid-frame aborts the frame; there is no partial-word recovery.
- **Input-to-frame latency:** the second input of a pair reaches frame at most 512 clocks later. When the pair completes at cnt==511, it loads in the same cycle.
- **First MSB bit** on I2S_SDATA: set in the cycle after cnt==7. It holds for 8 clocks per bit.
- **Phase relation:** SAMPLE_EN phase relative to cnt is arbitrary. Correct operation needs only one decimated sample per 512 clocks on average.
- UNDERRUN is asserted for exactly 1 clock, at cnt==0.
- The first frame after reset is always an underrun (frame=0), unless a pair completes before cnt==511.

## Test plan
- **Reset values:** hold RESET_N low 3 cycles, release → all outputs 0; I2S_MCLK toggles every clock, I2S_SCLK period 8, I2S_LRCK period 512 and low for first 256 clocks.
- **Decimation:** SAMPLE_IN=0x1000 then 0x2000 on successive strobes → frame=0x1800; left and right slots each shift out 0x1800 MSB-first, bits 1..16, zeros elsewhere.
- **Rounding:** pairs (−1, 0) → 0xFFFF; (0x7FFF, 0x7FFF) → 0x7FFF; (0x8000, 0x8000) → 0x8000.
- **Underrun:** stop SAMPLE_EN after one pair → next frame repeats the previous word and UNDERRUN pulses once per starved frame at cnt==0.
- **Bypass:** align so the pair completes at cnt==511 with SAMPLE_IN giving 0x0AAA → frame=0x0AAA in the same frame and no UNDERRUN.
- **Mute and reset:** assert MUTE during a left slot → the current frame finishes unchanged, the next frame is all zeros. Pulse RESET_N mid-right-slot → outputs 0 next cycle and the counter restarts at 0.
